chime_demultiplexer: RTL and testbench
======================================

Name: chime_demultiplexer

Overview:
- Inverse of the doorbell chime 2:1 selector: takes a single 24-bit sound/colour word stream and steers each word to one of two registered output channels (a, b).
- Each channel has a one-word holding register with a valid/ready handshake.
- Destination is either the external sel line (manual mode) or an internal alternating pointer (auto mode).
- Sits upstream of the chime selector and feeds its a/b inputs.

Parameters:
- WIDTH, 24, data word width of input and both output channels
- CNT_W, 8, width of the accepted-word counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  incoming word
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block accepts a word this cycle
- sel  input  1  manual destination select: 0 = channel a, 1 = channel b
- auto  input  1  1 = alternate destinations internally, ignoring sel
- out_a  output  WIDTH  channel a word
- out_a_valid  output  1  channel a holds an undelivered word
- out_a_ready  input  1  consumer of channel a takes the word
- out_b  output  WIDTH  channel b word
- out_b_valid  output  1  channel b holds an undelivered word
- out_b_ready  input  1  consumer of channel b takes the word
- count  output  CNT_W  number of words accepted, modulo 2^CNT_W

Behaviour:
- Reset (async, rst=1): out_a=0, out_b=0, out_a_valid=0, out_b_valid=0, count=0, toggle=0. in_ready=1 once rst is low.
- Destination select (combinational): dest = auto ? toggle : sel. dest=0 selects channel a; dest=1 selects channel b.
- in_ready (combinational): in_ready = !dest_valid || dest_ready.
  - A full channel whose consumer drains in the same cycle still accepts.
  - in_ready never depends on in_valid.
- Accept when in_valid && in_ready, at the rising edge:
  - dest data register <= in_data.
  - dest valid <= 1.
  - count <= count+1, wrapping 2^CNT_W-1 -> 0.
  - If auto=1, toggle <= ~toggle. If auto=0, toggle is unchanged.
- Drain when out_x_valid && out_x_ready:
  - out_x_valid <= 0, unless the same edge also loads channel x, in which case it stays 1 with the new data.
  - out_x data is not cleared on drain; it retains the last value.
- Latency: one cycle, accept edge to out_x_valid=1. No combinational path from in_data to out_x.
- Stability: while out_x_valid=1 and out_x_ready=0, out_x and out_x_valid hold constant.
- Independence:
  - Channels drain independently. A stalled channel blocks only words destined for it.
  - In auto mode, a stall on the pointed-to channel holds in_ready=0. There is no skipping ahead.
- Mode change:
  - auto or sel changes take effect combinationally the same cycle, since dest is recomputed.
  - Switching manual -> auto resumes from the current toggle value.
- Reset mid-operation: pending words are discarded, valids drop to 0 immediately (async), and count and toggle return to 0.

Test Plan:
- Reset then idle: rst pulse -> all outputs 0, in_ready=1, count=0.
- Manual routing: auto=0, sel=0, send 0xFF0000; then sel=1, send 0x00FF00 (both ready=1) -> out_a=0xFF0000 valid one cycle after accept, out_b=0x00FF00, count=2.
- Auto alternation: auto=1, ready=1, stream 0x000001..0x000004 -> a gets 1,3; b gets 2,4; toggle ends at 0; count=4.
- Back-pressure:
  - auto=0, sel=0, out_a_ready=0; send 0x123456, then attempt 0xABCDEF -> in_ready=0, out_a holds 0x123456.
  - Raise out_a_ready -> 0xABCDEF accepted in that same cycle; out_a_valid stays 1.
  - Switching to sel=1 while a is stalled -> in_ready=1, word goes to b.
- Counter wrap: 256 accepted words -> count returns to 0 and the 257th accept gives count=1.
- Async reset mid-stall: out_b_valid=1, out_b_ready=0, assert rst between clock edges -> out_b_valid=0 immediately, count=0.

Source files
------------

// File: rtl/chime_demultiplexer.sv
// chime_demultiplexer
//   Steers a single WIDTH-bit sound/colour word stream to one of two registered
//   output channels (a, b), each a one-word holding register with valid/ready.
//   Destination comes from the external sel line (manual) or from an internal
//   alternating pointer (auto). Feeds the a/b inputs of the chime selector.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   in_data      incoming word
//   in_valid     in_data is valid this cycle
//   in_ready     block accepts a word this cycle
//   sel          manual destination: 0 = channel a, 1 = channel b
//   auto         1 = alternate destinations internally, ignoring sel
//   out_a        channel a word
//   out_a_valid  channel a holds an undelivered word
//   out_a_ready  consumer of channel a takes the word
//   out_b        channel b word
//   out_b_valid  channel b holds an undelivered word
//   out_b_ready  consumer of channel b takes the word
//   count        number of words accepted, modulo 2^CNT_W
module chime_demultiplexer #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    input  logic             auto,
    output logic [WIDTH-1:0] out_a,
    output logic             out_a_valid,
    input  logic             out_a_ready,
    output logic [WIDTH-1:0] out_b,
    output logic             out_b_valid,
    input  logic             out_b_ready,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] a_data_q, a_data_d;
    logic [WIDTH-1:0] b_data_q, b_data_d;
    logic             a_valid_q, a_valid_d;
    logic             b_valid_q, b_valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             toggle_q, toggle_d;

    logic dest;
    logic dest_valid;
    logic dest_ready;
    logic accept;
    logic load_a;
    logic load_b;

    // Destination and acceptance. in_ready looks only at the addressed channel,
    // so a stalled channel never blocks words headed for the other one.
    always_comb begin
        dest       = auto ? toggle_q : sel;
        dest_valid = dest ? b_valid_q : a_valid_q;
        dest_ready = dest ? out_b_ready : out_a_ready;
        in_ready   = !dest_valid || dest_ready;
        accept     = in_valid && in_ready;
        load_a     = accept && !dest;
        load_b     = accept && dest;
    end

    // Next state. A load on the same edge as a drain wins, keeping valid high.
    always_comb begin
        a_data_d  = a_data_q;
        b_data_d  = b_data_q;
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;
        count_d   = count_q;
        toggle_d  = toggle_q;

        if (a_valid_q && out_a_ready) begin
            a_valid_d = 1'b0;
        end
        if (b_valid_q && out_b_ready) begin
            b_valid_d = 1'b0;
        end
        if (load_a) begin
            a_data_d  = in_data;
            a_valid_d = 1'b1;
        end
        if (load_b) begin
            b_data_d  = in_data;
            b_valid_d = 1'b1;
        end
        if (accept) begin
            count_d = count_q + 1'b1;
            if (auto) begin
                toggle_d = ~toggle_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_data_q  <= '0;
            b_data_q  <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            count_q   <= '0;
            toggle_q  <= 1'b0;
        end else begin
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            count_q   <= count_d;
            toggle_q  <= toggle_d;
        end
    end

    assign out_a       = a_data_q;
    assign out_b       = b_data_q;
    assign out_a_valid = a_valid_q;
    assign out_b_valid = b_valid_q;
    assign count       = count_q;

endmodule

// File: tb/tb_chime_demultiplexer.sv
// Testbench for chime_demultiplexer: table of per-cycle vectors with expected
// in_ready, plus a scoreboard queue per channel holding undelivered words.
module tb_chime_demultiplexer;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sel;
    logic             auto_s;
    logic [WIDTH-1:0] out_a;
    logic             out_a_valid;
    logic             out_a_ready;
    logic [WIDTH-1:0] out_b;
    logic             out_b_valid;
    logic             out_b_ready;
    logic [CNT_W-1:0] count;

    chime_demultiplexer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .auto       (auto_s),
        .out_a      (out_a),
        .out_a_valid(out_a_valid),
        .out_a_ready(out_a_ready),
        .out_b      (out_b),
        .out_b_valid(out_b_valid),
        .out_b_ready(out_b_ready),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             am;
        logic             sl;
        logic             vl;
        logic [WIDTH-1:0] dt;
        logic             ra;
        logic             rb;
        logic             rdy;
    } vec_t;

    vec_t vecs[$];

    // Scoreboard and reference state
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic [WIDTH-1:0] last_a;
    logic [WIDTH-1:0] last_b;
    logic [CNT_W-1:0] cnt_m;
    logic             tog_m;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic am, input logic sl, input logic vl,
                                input logic [WIDTH-1:0] dt, input logic ra, input logic rb,
                                input logic rdy);
        vec_t v;
        v.am = am; v.sl = sl; v.vl = vl; v.dt = dt; v.ra = ra; v.rb = rb; v.rdy = rdy;
        return v;
    endfunction

    task automatic model_clear();
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
        cnt_m  = '0;
        tog_m  = 1'b0;
    endtask

    // Called at a negedge: drive, check pre-edge state, update model, clock.
    task automatic step(input vec_t v);
        logic dest;
        logic acc;
        auto_s      = v.am;
        sel         = v.sl;
        in_valid    = v.vl;
        in_data     = v.dt;
        out_a_ready = v.ra;
        out_b_ready = v.rb;
        #1;
        chk("in_ready", {31'b0, in_ready}, {31'b0, v.rdy});
        chk("out_a_valid", {31'b0, out_a_valid}, {31'b0, qa.size() != 0});
        chk("out_b_valid", {31'b0, out_b_valid}, {31'b0, qb.size() != 0});
        chk("out_a", {8'b0, out_a}, {8'b0, (qa.size() != 0) ? qa[0] : last_a});
        chk("out_b", {8'b0, out_b}, {8'b0, (qb.size() != 0) ? qb[0] : last_b});
        if (v.ra && qa.size() != 0) void'(qa.pop_front());
        if (v.rb && qb.size() != 0) void'(qb.pop_front());
        dest = v.am ? tog_m : v.sl;
        acc  = v.vl && v.rdy;
        if (acc) begin
            if (dest) begin
                qb.push_back(v.dt);
                last_b = v.dt;
            end else begin
                qa.push_back(v.dt);
                last_a = v.dt;
            end
            cnt_m = cnt_m + 1'b1;
            if (v.am) tog_m = ~tog_m;
        end
        @(posedge clk);
        @(negedge clk);
        chk("count", {24'b0, count}, {24'b0, cnt_m});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        chk("rst out_a", {8'b0, out_a}, 32'h0);
        chk("rst out_b", {8'b0, out_b}, 32'h0);
        chk("rst valids", {30'b0, out_a_valid, out_b_valid}, 32'h0);
        chk("rst count", {24'b0, count}, 32'h0);
        chk("rst in_ready", {31'b0, in_ready}, 32'h1);
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        in_data     = '0;
        in_valid    = 1'b0;
        sel         = 1'b0;
        auto_s      = 1'b0;
        out_a_ready = 1'b1;
        out_b_ready = 1'b1;
        model_clear();

        //             auto sel vld data        ra rb rdy
        // Manual routing
        vecs.push_back(mk(0, 0, 1, 24'hFF0000, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 24'h00FF00, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 24'h000000, 1, 1, 1));
        // Auto alternation
        vecs.push_back(mk(1, 0, 1, 24'h000001, 1, 1, 1));
        vecs.push_back(mk(1, 0, 1, 24'h000002, 1, 1, 1));
        vecs.push_back(mk(1, 0, 1, 24'h000003, 1, 1, 1));
        vecs.push_back(mk(1, 0, 1, 24'h000004, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 24'h000000, 1, 1, 1));
        // Back-pressure on a, drain-and-load, reroute to b
        vecs.push_back(mk(0, 0, 1, 24'h123456, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 24'hABCDEF, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 24'hABCDEF, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 24'hABCDEF, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 24'h0B0B0B, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 24'h111111, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 24'h000000, 1, 1, 1));
        // Auto mode with a stall on the pointed-to channel: no skipping ahead
        vecs.push_back(mk(1, 0, 1, 24'h222222, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 24'h333333, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 24'h444444, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 24'h444444, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 24'h000000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 24'h000000, 1, 1, 1));
        // Manual -> auto resumes from toggle = 1, so this word lands on b
        vecs.push_back(mk(1, 0, 1, 24'h555555, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 24'h000000, 1, 1, 1));

        do_reset();
        foreach (vecs[i]) step(vecs[i]);
        chk("toggle resumed to b", {8'b0, last_b}, 32'h555555);

        // Counter wrap: 256 accepts return count to 0, the 257th gives 1
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(mk(0, 0, 1, WIDTH'(i), 1, 1, 1));
        end
        chk("wrap count 0", {24'b0, count}, 32'h0);
        step(mk(0, 0, 1, 24'hC0FFEE, 1, 1, 1));
        chk("wrap count 1", {24'b0, count}, 32'h1);
        step(mk(0, 0, 0, 24'h000000, 1, 1, 1));

        // Async reset mid-stall on b, between clock edges
        step(mk(0, 1, 1, 24'hBEEF00, 1, 0, 1));
        chk("stall b valid", {31'b0, out_b_valid}, 32'h1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async rst b_valid", {31'b0, out_b_valid}, 32'h0);
        chk("async rst count", {24'b0, count}, 32'h0);
        chk("async rst out_b", {8'b0, out_b}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        step(mk(0, 1, 0, 24'h000000, 1, 1, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
